// File: rtl/rst_seq_gen_if.sv
// Bundles the reset-sequencer request/ack handshake and the sequenced
// reset outputs.
//   sw_req    : software reset request (4-phase level handshake)
//   sw_ack    : software request complete, held until sw_req drops
//   ext_req   : external level reset request (e.g. watchdog)
//   rst_out_n : sequenced active-low resets, bit k released k-th
//   busy      : high while any rst_out_n bit is low
//   rel_done  : one-cycle pulse when the final output releases
// The master modport is the requester side; the slave modport is the
// generator.
interface rst_seq_gen_if #(
    parameter int NUM_OUT = 4
);
    logic               sw_req;
    logic               sw_ack;
    logic               ext_req;
    logic [NUM_OUT-1:0] rst_out_n;
    logic               busy;
    logic               rel_done;

    modport master (
        output sw_req, ext_req,
        input  sw_ack, rst_out_n, busy, rel_done
    );

    modport slave (
        input  sw_req, ext_req,
        output sw_ack, rst_out_n, busy, rel_done
    );
endinterface

// File: rtl/rst_seq_gen.sv
// Reset sequence generator for the top of the reset tree (always-on domain).
// After any reset cause, all rst_out_n bits are held low for HOLD_CYC cycles
// and then released one at a time in index order, GAP_CYC cycles apart.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset; restarts the full sequence
//   bus : rst_seq_gen_if slave modport (sw_req/sw_ack, ext_req, rst_out_n,
//         busy, rel_done)
module rst_seq_gen #(
    parameter int NUM_OUT  = 4,
    parameter int HOLD_CYC = 16,
    parameter int GAP_CYC  = 4,
    parameter int CNT_W    = 8
) (
    input logic          clk,
    input logic          rst,
    rst_seq_gen_if.slave bus
);

    localparam int STG_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [STG_W-1:0] LAST_STG  = STG_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REL
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [STG_W-1:0]   stage;      // index of the most recently released bit
    logic [STG_W-1:0]   stage_nxt;
    logic               src_sw;     // current sequence owes the software an ack
    logic [NUM_OUT-1:0] out_n;
    logic               busy_r;
    logic               ack_r;
    logic               done_r;

    always_comb begin
        stage_nxt = stage + STG_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= HOLD;
            cnt    <= '0;
            stage  <= '0;
            src_sw <= 1'b0;
            out_n  <= '0;
            busy_r <= 1'b1;
            ack_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            // Ack drops once the requester withdraws; a completion in this same
            // cycle (below) takes precedence.
            if (!bus.sw_req) begin
                ack_r <= 1'b0;
            end

            if (bus.ext_req) begin
                // Held at cnt=0 while ext_req stays high, stretching the pulse.
                // An aborted software sequence keeps src_sw so its ack still comes.
                state  <= HOLD;
                cnt    <= '0;
                stage  <= '0;
                out_n  <= '0;
                busy_r <= 1'b1;
                if (state == IDLE && bus.sw_req && !ack_r) begin
                    src_sw <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.sw_req && !ack_r) begin
                            state  <= HOLD;
                            cnt    <= '0;
                            stage  <= '0;
                            out_n  <= '0;
                            busy_r <= 1'b1;
                            src_sw <= 1'b1;
                        end
                    end

                    HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            cnt      <= '0;
                            stage    <= '0;
                            out_n[0] <= 1'b1;
                            if (NUM_OUT == 1) begin
                                // Single output: bit 0 is also the final release.
                                state  <= IDLE;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                                src_sw <= 1'b0;
                                if (src_sw) begin
                                    ack_r <= 1'b1;
                                end
                            end else begin
                                state <= REL;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    REL: begin
                        if (cnt == GAP_LAST) begin
                            cnt              <= '0;
                            stage            <= stage_nxt;
                            out_n[stage_nxt] <= 1'b1;
                            if (stage_nxt == LAST_STG) begin
                                state  <= IDLE;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                                src_sw <= 1'b0;
                                if (src_sw) begin
                                    ack_r <= 1'b1;
                                end
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    default: begin
                        state <= HOLD;
                        cnt   <= '0;
                        stage <= '0;
                        out_n <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.rst_out_n = out_n;
    assign bus.busy      = busy_r;
    assign bus.sw_ack    = ack_r;
    assign bus.rel_done  = done_r;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed self-checking bench for rst_seq_gen: default-parameter instance
// (4 outputs, 16/4 timing) plus a minimal instance (1 output, 1/1 timing).
module tb_rst_seq_gen;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rst_seq_gen_if #(.NUM_OUT(4)) bus_a ();
    rst_seq_gen_if #(.NUM_OUT(1)) bus_b ();

    rst_seq_gen #(
        .NUM_OUT  (4),
        .HOLD_CYC (16),
        .GAP_CYC  (4),
        .CNT_W    (8)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    rst_seq_gen #(
        .NUM_OUT  (1),
        .HOLD_CYC (1),
        .GAP_CYC  (1),
        .CNT_W    (8)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Expected 4-bit output pattern k cycles after the sequence origin.
    function automatic logic [3:0] exp_out(input int k);
        logic [3:0] v;
        v = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (k >= 16 + 4 * i) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Walk cycles k0..k1 of a default-parameter sequence, checking every output.
    task automatic walk(input string tag, input int k0, input int k1,
                        input logic ack, input logic chk_b);
        for (int k = k0; k <= k1; k++) begin
            @(negedge clk);
            chk($sformatf("%s_out@%0d", tag, k),  32'(bus_a.rst_out_n), 32'(exp_out(k)));
            chk($sformatf("%s_done@%0d", tag, k), 32'(bus_a.rel_done),  32'(k == 28));
            chk($sformatf("%s_busy@%0d", tag, k), 32'(bus_a.busy),      32'(k < 28));
            chk($sformatf("%s_ack@%0d", tag, k),  32'(bus_a.sw_ack),    32'(ack && k >= 28));
            if (chk_b) begin
                chk($sformatf("%s_b_out@%0d", tag, k),  32'(bus_b.rst_out_n), 32'(k >= 1));
                chk($sformatf("%s_b_done@%0d", tag, k), 32'(bus_b.rel_done),  32'(k == 1));
                chk($sformatf("%s_b_busy@%0d", tag, k), 32'(bus_b.busy),      32'(k < 1));
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus_a.sw_req  = 1'b0;
        bus_a.ext_req = 1'b0;
        bus_b.sw_req  = 1'b0;
        bus_b.ext_req = 1'b0;

        // Power-up: 5 cycles of reset, then release.
        repeat (5) @(negedge clk);
        chk("rst_out",  32'(bus_a.rst_out_n), 32'h0);
        chk("rst_busy", 32'(bus_a.busy),      32'h1);
        chk("rst_ack",  32'(bus_a.sw_ack),    32'h0);
        chk("rst_done", 32'(bus_a.rel_done),  32'h0);
        chk("rst_b_out", 32'(bus_b.rst_out_n), 32'h0);
        rst = 1'b0;
        walk("pwr", 1, 30, 1'b0, 1'b1);

        // Software handshake.
        bus_a.sw_req = 1'b1;
        @(negedge clk);
        chk("sw_c0_out",  32'(bus_a.rst_out_n), 32'h0);
        chk("sw_c0_busy", 32'(bus_a.busy),      32'h1);
        walk("sw", 1, 30, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("sw_hold_out%0d", i),  32'(bus_a.rst_out_n), 32'hF);
            chk($sformatf("sw_hold_busy%0d", i), 32'(bus_a.busy),      32'h0);
            chk($sformatf("sw_hold_ack%0d", i),  32'(bus_a.sw_ack),    32'h1);
        end
        bus_a.sw_req = 1'b0;
        @(negedge clk);
        chk("sw_ack_clear", 32'(bus_a.sw_ack),    32'h0);
        chk("sw_idle_out",  32'(bus_a.rst_out_n), 32'hF);

        // Watchdog stretch: 40 cycles of ext_req.
        bus_a.ext_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("wd_out%0d", i),  32'(bus_a.rst_out_n), 32'h0);
            chk($sformatf("wd_busy%0d", i), 32'(bus_a.busy),      32'h1);
        end
        bus_a.ext_req = 1'b0;
        walk("wd", 1, 30, 1'b0, 1'b0);

        // Abort mid-release at 0011.
        bus_a.ext_req = 1'b1;
        @(negedge clk);
        bus_a.ext_req = 1'b0;
        walk("ab_pre", 1, 21, 1'b0, 1'b0);
        bus_a.ext_req = 1'b1;
        @(negedge clk);
        chk("ab_out",  32'(bus_a.rst_out_n), 32'h0);
        chk("ab_busy", 32'(bus_a.busy),      32'h1);
        bus_a.ext_req = 1'b0;
        walk("ab", 1, 30, 1'b0, 1'b0);

        // Sync reset during a software sequence.
        bus_a.sw_req = 1'b1;
        @(negedge clk);
        chk("rs_c0_out", 32'(bus_a.rst_out_n), 32'h0);
        walk("rs_pre", 1, 16, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_out", 32'(bus_a.rst_out_n), 32'h0);
        chk("rs_ack", 32'(bus_a.sw_ack),    32'h0);
        rst          = 1'b0;
        bus_a.sw_req = 1'b0;
        walk("rs", 1, 30, 1'b0, 1'b0);
        bus_a.sw_req = 1'b1;
        @(negedge clk);
        chk("rs2_c0_out", 32'(bus_a.rst_out_n), 32'h0);
        walk("rs2", 1, 30, 1'b1, 1'b0);
        bus_a.sw_req = 1'b0;
        @(negedge clk);
        chk("rs2_ack_clear", 32'(bus_a.sw_ack), 32'h0);

        // Minimal instance: sw_req and ext_req in the same idle cycle.
        bus_b.sw_req  = 1'b1;
        bus_b.ext_req = 1'b1;
        @(negedge clk);
        chk("b_both_out",  32'(bus_b.rst_out_n), 32'h0);
        chk("b_both_busy", 32'(bus_b.busy),      32'h1);
        bus_b.ext_req = 1'b0;
        @(negedge clk);
        chk("b_k1_out",  32'(bus_b.rst_out_n), 32'h1);
        chk("b_k1_done", 32'(bus_b.rel_done),  32'h1);
        chk("b_k1_ack",  32'(bus_b.sw_ack),    32'h1);
        chk("b_k1_busy", 32'(bus_b.busy),      32'h0);
        @(negedge clk);
        chk("b_k2_done", 32'(bus_b.rel_done),  32'h0);
        chk("b_k2_ack",  32'(bus_b.sw_ack),    32'h1);
        chk("b_k2_out",  32'(bus_b.rst_out_n), 32'h1);
        bus_b.sw_req = 1'b0;
        @(negedge clk);
        chk("b_ack_clear", 32'(bus_b.sw_ack),    32'h0);
        chk("b_end_out",   32'(bus_b.rst_out_n), 32'h1);
        chk("b_end_busy",  32'(bus_b.busy),      32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
